led_heartbeat_engine: RTL and testbench
=======================================

LED_HEARTBEAT_ENGINE -- requirements
Module: led_heartbeat_engine

Interface
REQ-001 SHALL have parameter N_CH, default 8: number of LED channels (1..32).
REQ-002 SHALL have parameter TICK_DIV, default 300: clk cycles per pattern step (2..65535).
REQ-003 SHALL have parameter CH_W, default $clog2(N_CH) with minimum 1: channel index width.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_valid, input, 1: config write request.
REQ-007 SHALL have port cfg_ready, output, 1: config write may be accepted.
REQ-008 SHALL have port cfg_ch, input, CH_W: target channel.
REQ-009 SHALL have port cfg_mode, input, 2: mode code, where 0=OFF, 1=ON, 2=BLINK, 3=HEART.
REQ-010 SHALL have port cfg_err, output, 1: one-cycle pulse on an accepted write with cfg_ch >= N_CH.
REQ-011 SHALL have port step_tick, output, 1: one-cycle pulse at each step boundary.
REQ-012 SHALL have port led_out, output, N_CH: registered LED drive, active-high.

Function
REQ-013 SHALL count a prescaler 0..TICK_DIV-1, wrapping to 0; tick SHALL be asserted in the cycle the prescaler equals TICK_DIV-1.
REQ-014 SHALL drive step_tick registered, high for the one cycle after tick.
REQ-015 SHALL hold a 3-bit step counter that increments on tick and wraps from 7 to 0.
REQ-016 SHALL keep a 2-bit mode register per channel.
REQ-017 SHALL compute the channel pattern as follows: OFF=0; ON=1; BLINK=1 when step is even; HEART=1 only when step is 0 or 2.
REQ-018 SHALL register led_out[i] every cycle from the current mode[i] and step, giving a latency of 1 cycle from a step or mode change.
REQ-019 SHALL accept a write when cfg_valid && cfg_ready, capturing cfg_ch and cfg_mode into a single pending slot.
REQ-020 SHALL drive cfg_ready = !pending_valid (registered state).
REQ-021 SHALL apply a pending write to mode[cfg_ch] on the next tick and clear pending_valid in the same cycle.
REQ-022 SHALL make an applied mode visible on led_out one cycle after that tick, together with the new step.
REQ-023 SHALL treat a write accepted in a tick cycle as pending (its apply is not in that tick) and SHALL apply it at the following tick.
REQ-024 SHALL, for an accepted write with cfg_ch >= N_CH, not set pending, pulse cfg_err the next cycle, and leave all mode registers unchanged.
REQ-025 SHALL ignore cfg_valid while cfg_ready is low, with no state change and no cfg_err.
REQ-026 SHALL leave other channels' modes unaffected by a write.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear prescaler, step, all modes (OFF), pending_valid, led_out, step_tick and cfg_err to 0, and set cfg_ready to 1.
REQ-028 SHALL discard a pending write when reset is asserted mid-operation.
REQ-029 SHALL resume counting from prescaler 0 on the first clk edge after release.

Configuration
REQ-030 SHALL, when macro LED_HEARTBEAT_SYNC_EN is defined, add input sync_in (1 bit).
REQ-031 SHALL, while sync_in is high, clear prescaler and step to 0 next cycle and suppress tick.
REQ-032 SHALL keep any pending write across sync_in and apply it at the first tick after sync_in deasserts.
REQ-033 SHALL, without LED_HEARTBEAT_SYNC_EN, have no sync_in port and free-run the prescaler.

Verification (N_CH=4, TICK_DIV=4)
REQ-034 SHALL cover reset behaviour: rst_n released, no writes -> led_out=4'b0000 forever; step_tick every 4 cycles; step wraps 7->0 after 32 cycles.
REQ-035 SHALL cover mode application: write ch1=BLINK, then ch3=HEART -> cfg_ready is low after the first accept until the tick; ch1 toggles each step starting the cycle after the apply tick; ch3 is high only at steps 0 and 2.
REQ-036 SHALL cover simultaneous accept and tick: write ch0=ON accepted in the tick cycle -> led_out[0] is still 0 one cycle after that tick and becomes 1 one cycle after the next tick.
REQ-037 SHALL cover an out-of-range channel: write cfg_ch=5 -> cfg_err pulses one cycle, cfg_ready stays high, led_out unchanged.
REQ-038 SHALL cover reset mid-pending: write ch2=ON, then assert rst_n before the tick -> after release mode2=OFF, led_out[2]=0 and cfg_ready=1.
REQ-039 SHALL cover sync, with LED_HEARTBEAT_SYNC_EN defined: pulse sync_in at step 5 -> step=0 and prescaler=0 next cycle; next step_tick 4 cycles after sync_in falls.

Source files
------------

// File: rtl/led_heartbeat_engine.sv
// LED heartbeat engine: per-channel OFF/ON/BLINK/HEART patterns stepped by a prescaled tick.
// Optional feature macro LED_HEARTBEAT_SYNC_EN adds sync_in, which restarts the step sequence.
module led_heartbeat_engine #(
  parameter int N_CH     = 8,
  parameter int TICK_DIV = 300,
  parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef LED_HEARTBEAT_SYNC_EN
  input  logic              sync_in,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  output logic              cfg_err,
  output logic              step_tick,
  output logic [N_CH-1:0]   led_out
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CHW1 = CH_W + 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CH_W:0]   N_CH_L    = CHW1'(N_CH);

  logic                   sync_w;
  logic                   tick;
  logic                   accept;
  logic                   ch_bad;
  logic                   apply;
  logic [PW-1:0]          presc_q, presc_d;
  logic [2:0]             step_q, step_d;
  logic                   pend_q, pend_d;
  logic [CH_W-1:0]        pend_ch_q;
  logic [1:0]             pend_mode_q;
  logic [N_CH-1:0][1:0]   mode_q, mode_d;
  logic [N_CH-1:0]        led_d;
  logic [N_CH-1:0]        led_out_q;
  logic                   step_tick_q;
  logic                   cfg_err_q;

`ifdef LED_HEARTBEAT_SYNC_EN
  assign sync_w = sync_in;
`else
  assign sync_w = 1'b0;
`endif

  always_comb begin
    tick    = (presc_q == PRESC_MAX) && !sync_w;
    accept  = cfg_valid && !pend_q;
    ch_bad  = ({1'b0, cfg_ch} >= N_CH_L);
    apply   = tick && pend_q;
    presc_d = presc_q + PW'(1);
    step_d  = step_q;
    pend_d  = pend_q;
    if (sync_w) begin
      presc_d = '0;
      step_d  = '0;
    end else if (tick) begin
      presc_d = '0;
      step_d  = step_q + 3'd1;
    end
    // A write accepted in a tick cycle cannot coincide with an apply: ready implies nothing pending.
    if (apply) begin
      pend_d = 1'b0;
    end else if (accept && !ch_bad) begin
      pend_d = 1'b1;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign mode_d[gi] = (apply && (pend_ch_q == CH_W'(gi))) ? pend_mode_q : mode_q[gi];
    assign led_d[gi]  = (mode_q[gi] == 2'd1) ||
                        ((mode_q[gi] == 2'd2) && !step_q[0]) ||
                        ((mode_q[gi] == 2'd3) && ((step_q == 3'd0) || (step_q == 3'd2)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      step_q      <= '0;
      pend_q      <= 1'b0;
      pend_ch_q   <= '0;
      pend_mode_q <= '0;
      mode_q      <= '0;
      led_out_q   <= '0;
      step_tick_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      step_q      <= step_d;
      pend_q      <= pend_d;
      if (accept && !ch_bad) begin
        pend_ch_q   <= cfg_ch;
        pend_mode_q <= cfg_mode;
      end
      mode_q      <= mode_d;
      led_out_q   <= led_d;
      step_tick_q <= tick;
      cfg_err_q   <= accept && ch_bad;
    end
  end

  assign cfg_ready = !pend_q;
  assign cfg_err   = cfg_err_q;
  assign step_tick = step_tick_q;
  assign led_out   = led_out_q;

endmodule

// File: tb/tb_led_heartbeat_engine.sv
// Bench for led_heartbeat_engine (N_CH=4, TICK_DIV=4): directed steps plus random writes vs a cycle model.
module tb_led_heartbeat_engine;

  localparam int NCH = 4;
  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       sync_in;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic       cfg_err;
  logic       step_tick;
  logic [3:0] led_out;

  led_heartbeat_engine #(.N_CH(NCH), .TICK_DIV(DIV), .CH_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef LED_HEARTBEAT_SYNC_EN
    .sync_in   (sync_in),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_err   (cfg_err),
    .step_tick (step_tick),
    .led_out   (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ch;
    logic [1:0] mode;
  } wr_t;

  int         total = 0;
  int         bad   = 0;
  int         cyc_n = 0;
  // Model: k counts clk edges since reset release or last sync; step and tick follow arithmetically.
  int         k;
  int         m_mode [NCH];
  wr_t        pq [$];
  logic [3:0] exp_led;
  logic       exp_stick;
  logic       exp_err;
  logic       exp_ready;

  function automatic logic pat(int mode, int step);
    case (mode)
      1:       return 1'b1;
      2:       return (step % 2) == 0;
      3:       return (step == 0) || (step == 2);
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc_n);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < NCH; i++) m_mode[i] = 0;
    pq.delete();
  endtask

  // One clock: predict the registered outputs from the pre-edge state, clock, then compare.
  task automatic cyc();
    int  step_now;
    bit  tick_now;
    bit  acc;
    wr_t w;
    step_now = (k / DIV) % 8;
    tick_now = ((k % DIV) == DIV - 1) && !sync_in;
    for (int i = 0; i < NCH; i++) exp_led[i] = pat(m_mode[i], step_now);
    exp_stick = tick_now;
    acc       = cfg_valid && (pq.size() == 0);
    exp_err   = acc && (cfg_ch >= 3'(NCH));
    if (tick_now && pq.size() > 0) begin
      w = pq.pop_front();
      m_mode[w.ch] = int'(w.mode);
    end
    if (acc && cfg_ch < 3'(NCH)) begin
      w.ch   = cfg_ch;
      w.mode = cfg_mode;
      pq.push_back(w);
    end
    k = sync_in ? 0 : k + 1;
    exp_ready = (pq.size() == 0);
    if (acc) $display("write cycle=%0d ch=%0d mode=%0d %s", cyc_n, cfg_ch, cfg_mode,
                      exp_err ? "out-of-range" : "accepted");
    @(posedge clk);
    #1;
    cyc_n++;
    chk("led_out", 32'(led_out), 32'(exp_led));
    chk("step_tick", 32'(step_tick), 32'(exp_stick));
    chk("cfg_err", 32'(cfg_err), 32'(exp_err));
    chk("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
  endtask

  task automatic wr(input logic [2:0] ch, input logic [1:0] mode);
    bit done;
    done      = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = mode;
    for (int i = 0; i < 64 && !done; i++) begin
      done = (pq.size() == 0);
      cyc();
    end
    cfg_valid = 1'b0;
    chk("write_accept_bound", 32'(done), 32'd1);
  endtask

  // Idle until the model sits at a given prescaler phase with nothing pending.
  task automatic wait_phase(input int phase);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if ((k % DIV) == phase && pq.size() == 0) found = 1'b1;
      else cyc();
    end
    chk("wait_phase_bound", 32'(found), 32'd1);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_led"}, 32'(led_out), 32'd0);
    chk({tag, "_stick"}, 32'(step_tick), 32'd0);
    chk({tag, "_err"}, 32'(cfg_err), 32'd0);
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    sync_in   = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = '0;
    model_reset();
    #3;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: LEDs dark, step_tick every 4 cycles, step wraps after 32.
    repeat (40) cyc();

    // ch1 BLINK then ch3 HEART; second write waits for the first apply.
    wr(3'd1, 2'd2);
    wr(3'd3, 2'd3);
    repeat (40) cyc();

    // Write accepted in the tick cycle applies at the following tick.
    wait_phase(DIV - 1);
    wr(3'd0, 2'd1);
    repeat (12) cyc();

    // Out-of-range channel: error pulse, nothing pending.
    wr(3'd5, 2'd1);
    repeat (8) cyc();

    // Valid held while busy is ignored until the slot frees.
    wr(3'd2, 2'd3);
    cfg_valid = 1'b1;
    cfg_ch    = 3'd6;
    cfg_mode  = 2'd0;
    repeat (6) cyc();
    cfg_valid = 1'b0;
    repeat (4) cyc();

`ifdef LED_HEARTBEAT_SYNC_EN
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 64 && !hit; i++) begin
        if (((k / DIV) % 8) == 5) hit = 1'b1;
        else cyc();
      end
      chk("sync_wait_bound", 32'(hit), 32'd1);
      sync_in = 1'b1;
      cyc();
      sync_in = 1'b0;
      repeat (12) cyc();
    end
`endif

    // Random writes (and sync pulses when present).
    for (int i = 0; i < 400; i++) begin
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = 3'($urandom_range(0, 7));
      cfg_mode  = 2'($urandom_range(0, 3));
`ifdef LED_HEARTBEAT_SYNC_EN
      sync_in   = ($urandom_range(0, 39) == 0);
`endif
      cyc();
    end
    cfg_valid = 1'b0;
    sync_in   = 1'b0;
    repeat (12) cyc();

    // Reset while ch2=ON is still pending: the write is discarded.
    wait_phase(0);
    wr(3'd2, 2'd1);
    chk("pending_before_reset", 32'(cfg_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) cyc();
    chk("after_reset_led2", 32'(led_out[2]), 32'd0);
    chk("after_reset_ready", 32'(cfg_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
